// File: rtl/execute_stage_module.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution and the EX/MEM register.
// Optional iterative shift-add multiplier for ALUControlE=1011 is built only when EX_MUL_EN is defined.
module execute_stage_module #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            ResultSrcE,
    input  logic            MemWriteE,
    input  logic            JumpE,
    input  logic            BranchE,
    input  logic            JalrE,
    input  logic            ALUSrcE,
    input  logic [3:0]      ALUControlE,
    input  logic [2:0]      BranchOpE,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [4:0]      RdE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    input  logic            FlushE,
    output logic            RegWriteM,
    output logic            ResultSrcM,
    output logic            MemWriteM,
    output logic [4:0]      RdM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCTargetE,
    output logic            PCSrcE,
    output logic            StallE
);

    logic [XLEN-1:0] w_srca;
    logic [XLEN-1:0] w_write_data;
    logic [XLEN-1:0] w_srcb;
    logic [XLEN-1:0] w_alu_result;
    logic [4:0]      w_shamt;
    logic            w_cond;

    always_comb begin
        case (ForwardAE)
            2'b01:   w_srca = ResultW;
            2'b10:   w_srca = ALUResultM;
            default: w_srca = RD1E;
        endcase
        case (ForwardBE)
            2'b01:   w_write_data = ResultW;
            2'b10:   w_write_data = ALUResultM;
            default: w_write_data = RD2E;
        endcase
    end

    assign w_srcb  = ALUSrcE ? ImmExtE : w_write_data;
    assign w_shamt = w_srcb[4:0];

`ifdef EX_MUL_EN
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]      r_state;
    logic [4:0]      r_cnt;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [XLEN-1:0] r_acc;
    logic            w_issue;
    logic            w_mul_done;
    logic [XLEN-1:0] w_step_acc;

    assign w_issue    = (r_state == S_IDLE) && (ALUControlE == 4'b1011) && !FlushE;
    assign w_mul_done = (r_state == S_BUSY) && (r_cnt == 5'd31);
    // The last multiplier bit is folded in combinationally so the product lands on the cnt=31 cycle.
    assign w_step_acc = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign StallE     = w_issue || ((r_state == S_BUSY) && (r_cnt != 5'd31));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_state  <= S_BUSY;
                        r_cnt    <= '0;
                        r_mcand  <= w_srca;
                        r_mplier <= w_srcb;
                        r_acc    <= '0;
                    end
                end
                default: begin
                    if (FlushE || w_mul_done) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc    <= w_step_acc;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + 5'd1;
                    end
                end
            endcase
        end
    end
`else
    assign StallE = 1'b0;
`endif

    always_comb begin
        w_alu_result = '0;
        case (ALUControlE)
            4'b0000: w_alu_result = w_srca + w_srcb;
            4'b0001: w_alu_result = w_srca - w_srcb;
            4'b0010: w_alu_result = w_srca & w_srcb;
            4'b0011: w_alu_result = w_srca | w_srcb;
            4'b0100: w_alu_result = w_srca ^ w_srcb;
            4'b0101: w_alu_result = {{(XLEN-1){1'b0}}, ($signed(w_srca) < $signed(w_srcb))};
            4'b0110: w_alu_result = {{(XLEN-1){1'b0}}, (w_srca < w_srcb)};
            4'b0111: w_alu_result = w_srca << w_shamt;
            4'b1000: w_alu_result = w_srca >> w_shamt;
            4'b1001: w_alu_result = $unsigned($signed(w_srca) >>> w_shamt);
            4'b1010: w_alu_result = w_srcb;
`ifdef EX_MUL_EN
            4'b1011: w_alu_result = w_mul_done ? w_step_acc : '0;
`endif
            default: w_alu_result = '0;
        endcase
    end

    always_comb begin
        w_cond = 1'b0;
        case (BranchOpE)
            3'b000:  w_cond = (w_srca == w_write_data);
            3'b001:  w_cond = (w_srca != w_write_data);
            3'b100:  w_cond = ($signed(w_srca) < $signed(w_write_data));
            3'b101:  w_cond = ($signed(w_srca) >= $signed(w_write_data));
            3'b110:  w_cond = (w_srca < w_write_data);
            3'b111:  w_cond = (w_srca >= w_write_data);
            default: w_cond = 1'b0;
        endcase
    end

    assign PCSrcE    = JumpE | (BranchE & w_cond);
    assign PCTargetE = JalrE ? {w_alu_result[XLEN-1:1], 1'b0} : (PCE + ImmExtE);

    // Data fields load unconditionally; only the control bits are squashed for a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWriteM  <= 1'b0;
            ResultSrcM <= 1'b0;
            MemWriteM  <= 1'b0;
            RdM        <= '0;
            PCPlus4M   <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
        end else begin
            RegWriteM  <= (FlushE || StallE) ? 1'b0 : RegWriteE;
            ResultSrcM <= (FlushE || StallE) ? 1'b0 : ResultSrcE;
            MemWriteM  <= (FlushE || StallE) ? 1'b0 : MemWriteE;
            RdM        <= RdE;
            PCPlus4M   <= PCPlus4E;
            ALUResultM <= w_alu_result;
            WriteDataM <= w_write_data;
        end
    end

endmodule

// File: tb/tb_execute_stage_module.sv
// Scoreboard bench for execute_stage_module: EX/MEM expectations are queued at drive time and
// checked one edge later; combinational redirect and stall outputs are checked inline.
module tb_execute_stage_module;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, JalrE, ALUSrcE;
    logic [3:0]  ALUControlE;
    logic [2:0]  BranchOpE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW;
    logic [4:0]  RdE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        FlushE;
    logic        RegWriteM, ResultSrcM, MemWriteM;
    logic [4:0]  RdM;
    logic [31:0] PCPlus4M, ALUResultM, WriteDataM, PCTargetE;
    logic        PCSrcE, StallE;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        rw, rs, mw;
        logic [4:0]  rd;
        logic [31:0] pc4, alu, wd;
        bit          chk;
        int          id;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   push_id = 0;

    execute_stage_module #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .JalrE(JalrE), .ALUSrcE(ALUSrcE),
        .ALUControlE(ALUControlE), .BranchOpE(BranchOpE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RdE(RdE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .FlushE(FlushE),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM), .RdM(RdM),
        .PCPlus4M(PCPlus4M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCTargetE(PCTargetE), .PCSrcE(PCSrcE), .StallE(StallE)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: the entry pushed in a cycle is popped at the edge that registers it.
    always @(posedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            #1;
            checks++;
            if ({RegWriteM, ResultSrcM, MemWriteM} !== {mon_e.rw, mon_e.rs, mon_e.mw}) begin
                failures++;
                $display("FAIL m_ctrl#%0d got=%b%b%b exp=%b%b%b", mon_e.id, RegWriteM, ResultSrcM,
                         MemWriteM, mon_e.rw, mon_e.rs, mon_e.mw);
            end
            if (mon_e.chk) begin
                checks++;
                if (RdM !== mon_e.rd || PCPlus4M !== mon_e.pc4) begin
                    failures++;
                    $display("FAIL m_rd_pc4#%0d got=%0d/%h exp=%0d/%h", mon_e.id, RdM, PCPlus4M,
                             mon_e.rd, mon_e.pc4);
                end
                checks++;
                if (ALUResultM !== mon_e.alu || WriteDataM !== mon_e.wd) begin
                    failures++;
                    $display("FAIL m_data#%0d got=%h/%h exp=%h/%h", mon_e.id, ALUResultM,
                             WriteDataM, mon_e.alu, mon_e.wd);
                end
            end
        end
    end

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:    return (a < b) ? 32'd1 : 32'd0;
            4'd7:    return a << b[4:0];
            4'd8:    return a >> b[4:0];
            4'd9:    return $unsigned($signed(a) >>> b[4:0]);
            4'd10:   return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit br_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic push(input logic rw, input logic rs, input logic mw, input logic [4:0] rd,
                        input logic [31:0] pc4, input logic [31:0] alu, input logic [31:0] wd,
                        input bit chk);
        exp_t e;
        e.rw = rw; e.rs = rs; e.mw = mw; e.rd = rd;
        e.pc4 = pc4; e.alu = alu; e.wd = wd; e.chk = chk; e.id = push_id++;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        rst = 0; FlushE = 0;
        RegWriteE = 0; ResultSrcE = 0; MemWriteE = 0; JumpE = 0; BranchE = 0; JalrE = 0; ALUSrcE = 0;
        ALUControlE = 0; BranchOpE = 3'd2; RD1E = 0; RD2E = 0; ImmExtE = 0; PCE = 0; PCPlus4E = 0;
        RdE = 0; ForwardAE = 0; ForwardBE = 0; ResultW = 0;
    endtask

    task automatic test_reset();
        nop();
        rst = 1; RegWriteE = 1; ResultSrcE = 1; MemWriteE = 1; RdE = 7; RD1E = 123; RD2E = 9;
        PCPlus4E = 32'h44;
        push(0, 0, 0, 0, 0, 0, 0, 1);
        cyc();
        checks++;
        if (StallE !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall got=%b exp=0", StallE);
        end
        nop();
    endtask

    task automatic test_alu_fwd();
        nop();
        RD1E = 5; ALUSrcE = 1; ImmExtE = 7; RdE = 3; RegWriteE = 1; RD2E = 9; PCPlus4E = 32'h14;
        push(1, 0, 0, 3, 32'h14, 32'd12, 32'd9, 1);
        cyc();
        nop();
        ALUControlE = 4'd1; ForwardAE = 2'b10; RD1E = 32'hdead; RD2E = 2; RdE = 4; RegWriteE = 1;
        push(1, 0, 0, 4, 0, 32'd10, 32'd2, 1);
        cyc();
        ForwardAE = 2'b01; ResultW = 100;
        push(1, 0, 0, 4, 0, 32'd98, 32'd2, 1);
        cyc();
        ALUControlE = 4'd0; ForwardAE = 2'b00; RD1E = 2; ForwardBE = 2'b10; RD2E = 777; ResultW = 0;
        push(1, 0, 0, 4, 0, 32'd100, 32'd98, 1);
        cyc();
        ForwardAE = 2'b11; RD1E = 50; ForwardBE = 2'b01; ResultW = 5;
        push(1, 0, 0, 4, 0, 32'd55, 32'd5, 1);
        cyc();
        nop();
    endtask

    task automatic test_alu_ops();
        logic [31:0] av [4];
        logic [31:0] bv [4];
        av[0] = 32'h80000001; bv[0] = 32'h00000023;
        av[1] = 32'h00000007; bv[1] = 32'hFFFFFFF9;
        av[2] = $urandom;     bv[2] = $urandom;
        av[3] = 32'h80000000; bv[3] = 32'h00000004;
        for (int p = 0; p < 4; p++) begin
            for (int op = 0; op < 16; op++) begin
`ifdef EX_MUL_EN
                if (op == 11) continue;
`endif
                nop();
                ALUControlE = op[3:0]; RD1E = av[p]; RD2E = bv[p]; RegWriteE = 1; RdE = op[4:0];
                PCPlus4E = 32'h1000 + op;
                push(1, 0, 0, op[4:0], 32'h1000 + op, alu_ref(op[3:0], av[p], bv[p]), bv[p], 1);
                checks++;
                if (StallE !== 1'b0) begin
                    failures++;
                    $display("FAIL alu_stall op=%0d got=%b exp=0", op, StallE);
                end
                cyc();
            end
        end
        nop();
        ALUControlE = 4'd9; RD1E = 32'h80000000; ALUSrcE = 1; ImmExtE = 32'hFFFFFFE4;
        push(0, 0, 0, 0, 0, 32'hF8000000, 32'd0, 1);
        cyc();
        ALUControlE = 4'd7; RD1E = 32'h3; ImmExtE = 32'd33;
        push(0, 0, 0, 0, 0, 32'h6, 32'd0, 1);
        cyc();
        nop();
    endtask

    task automatic test_branch();
        logic [31:0] av [3];
        logic [31:0] bv [3];
        av[0] = 32'hFFFFFFFF; bv[0] = 32'd1;
        av[1] = 32'd5;        bv[1] = 32'd5;
        av[2] = 32'd3;        bv[2] = 32'd9;
        nop();
        ALUControlE = 4'd1; BranchE = 1; BranchOpE = 3'b100; RD1E = 32'hFFFFFFFF; RD2E = 1;
        PCE = 32'h100; ImmExtE = 32'h20;
        #1;
        checks++;
        if (PCSrcE !== 1'b1 || PCTargetE !== 32'h120) begin
            failures++;
            $display("FAIL blt got=%b/%h exp=1/00000120", PCSrcE, PCTargetE);
        end
        push(0, 0, 0, 0, 0, 32'hFFFFFFFE, 32'd1, 1);
        cyc();
        BranchOpE = 3'b110;
        #1;
        checks++;
        if (PCSrcE !== 1'b0) begin
            failures++;
            $display("FAIL bltu got=%b exp=0", PCSrcE);
        end
        push(0, 0, 0, 0, 0, 32'hFFFFFFFE, 32'd1, 1);
        cyc();
        for (int p = 0; p < 3; p++) begin
            for (int op = 0; op < 8; op++) begin
                BranchOpE = op[2:0]; RD1E = av[p]; RD2E = bv[p]; PCE = 32'h200 + 4 * p;
                ImmExtE = 32'hFFFFFFF0;
                #1;
                checks++;
                if (PCSrcE !== br_ref(op[2:0], av[p], bv[p]) || PCTargetE !== 32'h1F0 + 4 * p) begin
                    failures++;
                    $display("FAIL br op=%0d p=%0d got=%b/%h exp=%b/%h", op, p, PCSrcE, PCTargetE,
                             br_ref(op[2:0], av[p], bv[p]), 32'h1F0 + 4 * p);
                end
                push(0, 0, 0, 0, 0, av[p] - bv[p], bv[p], 1);
                cyc();
            end
        end
        BranchE = 0; JumpE = 1; BranchOpE = 3'd2;
        #1;
        checks++;
        if (PCSrcE !== 1'b1) begin
            failures++;
            $display("FAIL jal got=%b exp=1", PCSrcE);
        end
        push(0, 0, 0, 0, 0, av[2] - bv[2], bv[2], 1);
        cyc();
        nop();
    endtask

    task automatic test_jalr();
        nop();
        RD1E = 32'h203; ImmExtE = 0; ALUSrcE = 1; JalrE = 1; JumpE = 1; RegWriteE = 1; RdE = 1;
        PCE = 32'h100; PCPlus4E = 32'h104; RD2E = 32'h55;
        #1;
        checks++;
        if (PCSrcE !== 1'b1 || PCTargetE !== 32'h202) begin
            failures++;
            $display("FAIL jalr got=%b/%h exp=1/00000202", PCSrcE, PCTargetE);
        end
        push(1, 0, 0, 1, 32'h104, 32'h203, 32'h55, 1);
        cyc();
        nop();
    endtask

    task automatic test_flush();
        nop();
        MemWriteE = 1; RegWriteE = 1; ResultSrcE = 1; RdE = 9; RD1E = 32'h40; ImmExtE = 4; ALUSrcE = 1;
        RD2E = 32'hCAFE; FlushE = 1;
        push(0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        FlushE = 0;
        push(1, 1, 1, 9, 0, 32'h44, 32'hCAFE, 1);
        cyc();
        FlushE = 1;
        push(0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        FlushE = 0;
        push(1, 1, 1, 9, 0, 32'h44, 32'hCAFE, 1);
        cyc();
        rst = 1; FlushE = 1;
        push(0, 0, 0, 0, 0, 0, 0, 1);
        cyc();
        nop();
    endtask

`ifdef EX_MUL_EN
    task automatic test_mul();
        logic [31:0] av [2];
        logic [31:0] bv [2];
        logic [31:0] prod;
        av[0] = 32'h10000;    bv[0] = 32'h10001;
        av[1] = 32'hFFFFFFFF; bv[1] = 32'hFFFFFFFF;
        for (int p = 0; p < 2; p++) begin
            nop();
            prod = av[p] * bv[p];
            ALUControlE = 4'd11; RD1E = av[p]; RD2E = bv[p]; RegWriteE = 1; RdE = 5; PCPlus4E = 32'h40;
            for (int i = 0; i < 33; i++) begin
                checks++;
                if (StallE !== (i < 32)) begin
                    failures++;
                    $display("FAIL mul_stall p=%0d i=%0d got=%b exp=%b", p, i, StallE, (i < 32));
                end
                if (i < 32) push(0, 0, 0, 0, 0, 0, 0, 0);
                else        push(1, 0, 0, 5, 32'h40, prod, bv[p], 1);
                cyc();
            end
            nop();
        end
        ALUControlE = 4'd11; RD1E = 32'h1234; RD2E = 32'h77; RegWriteE = 1; RdE = 6;
        for (int i = 0; i < 11; i++) begin
            push(0, 0, 0, 0, 0, 0, 0, 0);
            cyc();
        end
        FlushE = 1;
        push(0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        nop();
        checks++;
        if (StallE !== 1'b0) begin
            failures++;
            $display("FAIL mul_abort_stall got=%b exp=0", StallE);
        end
        push(0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        nop();
    endtask
`endif

    initial begin
        nop();
        rst = 1;
        test_reset();
        test_alu_fwd();
        test_alu_ops();
        test_branch();
        test_jalr();
        test_flush();
`ifdef EX_MUL_EN
        test_mul();
`endif
        cyc();
        cyc();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
